if_fetch: RTL
=============

# if_fetch

Instruction-fetch front end sitting between `pc_gen` and the instruction memory port. It consumes the PC stream from `pc_gen` and issues in-order requests on a valid/ready request channel. It captures in-order responses into a tagged instruction buffer and delivers {pc, instr} pairs to decode over a valid/ready handshake. It drives `pc_gen`'s `stall_i` and discards stale responses after a branch redirect.

## Interface
- `DEPTH`, default 4: instruction buffer entries. This is also the maximum number of requests in flight. Power of two, at least 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `pc_i`  in  32  current PC from `pc_gen` `pc_o`.
- `flush_i`  in  1  redirect, i.e. branch taken; same cycle as `pc_gen` `branch_taken_i`.
- `stall_o`  out  1  to `pc_gen` `stall_i`; 1 means hold the PC.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  memory accepts the request.
- `imem_addr_o`  out  32  request address, equal to {pc_i[31:2], 2'b00}.
- `imem_rsp_valid_i`  in  1  response valid. Responses are in request order and always accepted; there is no ready.
- `imem_rsp_data_i`  in  32  response instruction word.
- `instr_valid_o`  out  1  instruction available to decode.
- `instr_ready_i`  in  1  decode accepts.
- `instr_o`  out  32  instruction word at the buffer head.
- `instr_pc_o`  out  32  PC of `instr_o`.

## Operation
- **Buffer.** A circular FIFO of DEPTH entries, each holding {pc, data, filled}. It has three pointers:
  - alloc (write pc);
  - fill (write data);
  - head (read).
  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The counters `used` (allocated entries) and `drop_cnt` are $clog2(DEPTH+1) bits.
- **Credit.** Computed from registered state only, with no same-cycle pop bypass: credit = (used + drop_cnt < DEPTH).
- **Request.**
  - imem_req_valid_o = credit & !flush_i.
  - fire = imem_req_valid_o & imem_req_ready_i.
  - On fire, allocate an entry at alloc with pc = pc_i and filled = 0.
- **Stall.** stall_o = !fire & !flush_i. The PC advances only on an accepted request.
  - stall_o is forced low in a flush cycle so that `pc_gen`, where stall has priority over branch, loads the branch target.
- **Response.**
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise data is written to the entry at fill, filled is set, and fill advances.
  - A response with no allocated unfilled entry and drop_cnt = 0 is a protocol violation and is ignored, with no state change.
- **Delivery.**
  - instr_valid_o = head entry allocated & filled & !flush_i.
  - On instr_valid_o & instr_ready_i, the head is popped and `used` decrements.
- **Flush** (flush_i = 1) takes priority over every other event in the same cycle:
  - No request is issued and no pop occurs.
  - All buffer entries are invalidated: used = 0, and alloc, fill and head are set equal.
  - drop_cnt_next = drop_cnt + (allocated-unfilled count) − imem_rsp_valid_i. A response arriving in the flush cycle is itself discarded.
- **Simultaneous events outside flush.** Fire, response and pop in one cycle all take effect; `used` changes by (+fire − pop).
- **Reset** (rst_ni = 0 at an edge) clears all pointers, `used` and drop_cnt. Reset mid-operation drops all in-flight state. The memory is reset together with the core, so no stale responses are expected.

## Timing
- Reset values: stall_o = 1 and imem_req_valid_o = 0 while rst_ni = 0. After reset release the buffer is empty, so imem_req_valid_o = 1 and stall_o follows !imem_req_ready_i. instr_valid_o = 0, instr_o = 0, instr_pc_o = 0. Outputs are evaluated from registered state.
- Request channel: combinational from registered state plus flush_i and imem_req_ready_i. imem_addr_o tracks pc_i combinationally.
- Response to instr_valid_o: 1 cycle. A response at edge E makes instr_valid_o high in the cycle after E.
- Fire to instr_valid_o: 2 cycles minimum, with a memory that responds the cycle after acceptance.
- Sustained throughput is 1 instruction/cycle with DEPTH ≥ 3, a 1-cycle memory and decode always ready. With DEPTH = 2 it is 2 per 3 cycles.
- Backpressure: with decode not ready, at most DEPTH requests are accepted. Then credit = 0, imem_req_valid_o = 0, and stall_o = 1 until a pop.
- Flush: stale responses are dropped for exactly drop_cnt responses. New-stream requests issue from the cycle after flush, while stale responses drain, within credit.

## Test plan
- **Reset and boot.** Drive rst_ni = 0 for 2 cycles; pc_gen BOOT_ADDR = 0x1000; memory has 1-cycle latency, always ready, and returns data = addr ^ 0xA5A5_0000; decode always ready.
  - During reset: stall_o = 1 and instr_valid_o = 0.
  - After release: instr_pc_o sequence 0x1000, 0x1004, 0x1008 with instr_o = 0xA5A5_1000, …, back-to-back with no bubbles after the first.
- **Memory backpressure.** imem_req_ready_i = 0 for 3 cycles at pc 0x1008 → stall_o = 1 for those 3 cycles, pc_i holds 0x1008, and 0x1008 is delivered exactly once.
- **Decode backpressure.** instr_ready_i = 0 for 8 cycles → exactly 4 requests accepted. Then imem_req_valid_o = 0 and stall_o = 1. instr_o holds its value. On release, the 4 buffered instructions are delivered in order.
- **Flush with in-flight responses.** Memory latency is 3 cycles and 2 requests are outstanding. Pulse flush_i with target 0x5000 → the 2 stale responses are dropped and the next delivered instr_pc_o = 0x5000, then 0x5004.
- **Flush coincident with a response and a pop.**
  - In the flush cycle: instr_valid_o = 0, no pop, and the response is discarded.
  - drop_cnt equals the remaining in-flight count.
  - The first delivered PC equals the target.
- **Reset mid-stream.** Buffer holds 3 entries and 1 is in flight; assert rst_ni = 0 for 1 cycle → instr_valid_o = 0 the next cycle, and the fetch restarts cleanly at 0x1000.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end between pc_gen and the instruction
// memory port.
//
// Fetch requests go out in order on a valid/ready channel. Each accepted
// request allocates a slot in a circular buffer. Responses come back in
// order and fill those slots. The buffer head is handed to decode as a
// {pc, instr} pair. A flush (taken branch) empties the buffer. Responses
// that are still owed for the old stream are counted and dropped as they
// arrive.
//
// Ports
//   clk_i, rst_ni        clock; synchronous active-low reset
//   pc_i                 current PC from pc_gen
//   flush_i              redirect (branch taken)
//   stall_o              hold request to pc_gen
//   imem_req_valid_o/ready_i, imem_addr_o   fetch request channel
//   imem_rsp_valid_i, imem_rsp_data_i       in-order response (no ready)
//   instr_valid_o/ready_i, instr_o, instr_pc_o  delivery to decode
module if_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] pc_q, pc_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic [DEPTH-1:0]       filled_q, filled_d;
  logic [PW-1:0]          alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  // used: allocated slots; pend: allocated but not yet filled;
  // drop: responses still owed to a flushed stream
  logic [CW-1:0]          used_q, used_d, pend_q, pend_d, drop_q, drop_d;
  logic [CW-1:0]          stale_sum;
  logic                   credit, req_valid, fire, head_ok, pop;
  logic                   rsp_drop, rsp_take;

  // Credit is computed from registered state only. A pop in this cycle does
  // not free a slot until the next cycle. Owed stale responses also hold
  // credit, so a slot cannot be reused before its old response has drained.
  assign credit    = ({1'b0, used_q} + {1'b0, drop_q}) < DEPTH_W;
  assign req_valid = rst_ni & credit & ~flush_i;
  assign fire      = req_valid & imem_req_ready_i;

  // Responses fill slots in order, so the head holds valid data exactly
  // when its filled bit is set.
  assign head_ok   = rst_ni & (used_q != '0) & filled_q[head_q];
  assign pop       = head_ok & ~flush_i & instr_ready_i;

  assign rsp_drop  = imem_rsp_valid_i & (drop_q != '0);
  // A response with nothing to fill and nothing owed is ignored.
  assign rsp_take  = imem_rsp_valid_i & (drop_q == '0) & (pend_q != '0);
  assign stale_sum = drop_q + pend_q;

  assign imem_req_valid_o = req_valid;
  assign imem_addr_o      = {pc_i[31:2], 2'b00};
  // Stall is released during a flush so that pc_gen, where stall has
  // priority over branch, loads the branch target.
  assign stall_o          = ~rst_ni | (~fire & ~flush_i);
  assign instr_valid_o    = head_ok & ~flush_i;
  assign instr_o          = head_ok ? data_q[head_q] : 32'h0;
  assign instr_pc_o       = head_ok ? pc_q[head_q]   : 32'h0;

  always_comb begin
    pc_d     = pc_q;
    data_d   = data_q;
    filled_d = filled_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    used_d   = used_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    if (flush_i) begin
      // Every unfilled slot becomes a stale response still owed by memory.
      // A response arriving in this same cycle pays off one of them.
      used_d = '0;
      pend_d = '0;
      fill_d = alloc_q;
      head_d = alloc_q;
      drop_d = (imem_rsp_valid_i && stale_sum != '0) ? stale_sum - CW'(1)
                                                     : stale_sum;
    end else begin
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (rsp_take) begin
        data_d[fill_q]   = imem_rsp_data_i;
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      // fill_q != alloc_q whenever both fire (credit keeps the ring from
      // being full), so these slot writes never collide.
      if (fire) begin
        pc_d[alloc_q]     = pc_i;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      used_d = used_q + CW'(fire) - CW'(pop);
      pend_d = pend_q + CW'(fire) - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      used_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      used_q  <= used_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Slot payload needs no reset: used_q == 0 marks every slot invalid.
  always_ff @(posedge clk_i) begin
    pc_q     <= pc_d;
    data_q   <= data_d;
    filled_q <= filled_d;
  end
endmodule
